// File: rtl/dmem_responder.sv
//==============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory responder for the MIPS datapath. It accepts one
//            load/store, adds WAIT_CYCLES wait states while holding the PC via
//            stall, then ends with a one-cycle ready/err pulse.
// Options  : `define DMEM_PERF_CNT_EN adds rd_count/wr_count access counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              ready,
    output logic              err
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    localparam int         AW          = $clog2(DEPTH);
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;
    localparam bit         c_no_wait   = (WAIT_CYCLES == 0);
    // cycle 0 is spent in IDLE, so WAIT holds for WAIT_CYCLES cycles in total
    localparam logic [3:0] c_cnt_init  = c_no_wait ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [AW+1:0]     r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rd;
    logic              r_wr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_req;
    logic              w_in_idle;
    logic              w_go;
    logic [AW+1:0]     w_a;
    logic [DATA_W-1:0] w_d;
    logic              w_rd;
    logic              w_wr;
    logic              w_bad;
    logic [AW-1:0]     w_idx;
    logic              w_we;
    logic              w_unused;

    assign w_req     = mem_read | mem_write;
    assign w_in_idle = (r_state == c_st_idle);

    // With zero wait states the access happens at the edge closing cycle 0,
    // so the live inputs are used instead of the latched copies.
    assign w_go  = ((r_state == c_st_wait) && (r_cnt == 4'd0)) ||
                   (w_in_idle && w_req && c_no_wait);
    assign w_a   = w_in_idle ? addr[AW+1:0] : r_addr;
    assign w_d   = w_in_idle ? wdata : r_wdata;
    assign w_rd  = w_in_idle ? mem_read : r_rd;
    assign w_wr  = w_in_idle ? mem_write : r_wr;
    assign w_bad = (w_a[1:0] != 2'b00) | (w_rd & w_wr);
    assign w_idx = w_a[AW+1:2];
    assign w_we  = w_go & w_wr & ~w_bad;

    assign stall = (w_in_idle && w_req) || (r_state == c_st_wait);

    assign w_unused = &{1'b0, addr[31:AW+2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            rdata   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
`ifdef DMEM_PERF_CNT_EN
            rd_count <= 32'd0;
            wr_count <= 32'd0;
`endif
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_req) begin
                        r_addr  <= addr[AW+1:0];
                        r_wdata <= wdata;
                        r_rd    <= mem_read;
                        r_wr    <= mem_write;
                        r_cnt   <= c_cnt_init;
                        r_state <= c_no_wait ? c_st_done : c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase

            if (w_go) begin
                ready <= 1'b1;
                err   <= w_bad;
                if (w_bad) begin
                    if (w_rd) begin
                        rdata <= '0;
                    end
                end else if (w_rd) begin
                    rdata <= r_mem[w_idx];
                end
`ifdef DMEM_PERF_CNT_EN
                if (!w_bad && w_rd) rd_count <= rd_count + 32'd1;
                if (!w_bad && w_wr) wr_count <= wr_count + 32'd1;
`endif
            end
        end
    end

    // Array has no reset; a reset landing on the access edge blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && w_we) begin
            r_mem[w_idx] <= w_d;
        end
    end

endmodule

`default_nettype wire
